// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial adder path.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Parallel-side handshake and serial monitor bundle for serial_add_ctrl.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout;
  logic             ser_a;
  logic             ser_b;
  logic             ser_s;

  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum_out, cout, ser_a, ser_b, ser_s
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum_out, cout, ser_a, ser_b, ser_s
  );
endinterface

// File: rtl/serial_fa_cell.sv
// One-bit full-adder cell with a registered carry; load takes priority over en.
module serial_fa_cell (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic load_val,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  import serial_arith_pkg::*;

  assign s = a ^ b ^ c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      c <= 1'b0;
    else if (load)
      c <= load_val;
    else if (en)
      c <= maj3(a, b, c);
  end
endmodule

// File: rtl/serial_add_ctrl.sv
// Parallel start/busy/done front end that runs an LSB-first bit-serial add.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  serial_add_ctrl_if.slave  bus
);
  import serial_arith_pkg::*;

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [CNT_W-1:0] cnt;
  logic             shifting;
  logic             accept;
  logic             s;
  logic             carry;

  assign shifting = (state == SHIFT);
  assign accept   = bus.start && ((state == IDLE) || (state == DONE));

  serial_fa_cell u_cell (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (bus.cin),
    .en       (shifting),
    .a        (a_sr[0]),
    .b        (b_sr[0]),
    .s        (s),
    .c        (carry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sr   <= bus.a_in;
            b_sr   <= bus.b_in;
            sum_sr <= '0;
            cnt    <= '0;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          sum_sr <= {s, sum_sr[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Result is taken from the next-state values so it lands with done.
            sum_q  <= {s, sum_sr[WIDTH-1:1]};
            cout_q <= maj3(a_sr[0], b_sr[0], carry);
            cnt    <= '0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = shifting;
  assign bus.done    = (state == DONE);
  assign bus.sum_out = sum_q;
  assign bus.cout    = cout_q;
  assign bus.ser_a   = shifting & a_sr[0];
  assign bus.ser_b   = shifting & b_sr[0];
  assign bus.ser_s   = shifting & s;
endmodule
